// File: rtl/hazard_controller_if.sv
// Decode-stage hazard controller bus.
//   master : decode stage. It drives the ID instruction fields, the branch
//            outcome and the memory-busy flag, and receives the forwarding
//            selects, stall/flush controls and the stall counter.
//   slave  : hazard_controller.
// CNT_W is the width of stall_count_o.
interface hazard_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic [4:0]       id_rd_i;
  logic             id_we_i;
  logic             id_load_i;
  logic             id_serial_i;
  logic             id_branch_i;
  logic             id_jump_i;
  logic             take_branch_i;
  logic             mem_busy_i;
  logic [1:0]       forward_a_sel_o;
  logic [1:0]       forward_b_sel_o;
  logic             if_stall_o;
  logic             id_stall_o;
  logic             id_flush_o;
  logic             if_flush_o;
  logic [CNT_W-1:0] stall_count_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_we_i, id_load_i, id_serial_i, id_branch_i,
           id_jump_i, take_branch_i, mem_busy_i,
    input  forward_a_sel_o, forward_b_sel_o, if_stall_o, id_stall_o,
           id_flush_o, if_flush_o, stall_count_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_we_i, id_load_i, id_serial_i, id_branch_i,
           id_jump_i, take_branch_i, mem_busy_i,
    output forward_a_sel_o, forward_b_sel_o, if_stall_o, id_stall_o,
           id_flush_o, if_flush_o, stall_count_o
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard and sequencing controller for the decode stage.
// Tracks destinations in flight in EX/MEM/WB, drives the decode forwarding
// selects and generates IF/ID stalls, ID/EX bubbles and IF flushes for
// load-use, redirects, serial (CSR/system) ops and data-memory wait.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   hz    : hazard_controller_if.slave (ID fields in, controls/counter out)
//     forward_x_sel_o : 0=regfile 1=EX 2=MEM 3=WB
//     if_stall_o      : hold PC and IF/ID
//     id_stall_o      : hold ID/EX (memory freeze only)
//     id_flush_o      : bubble into ID/EX
//     if_flush_o      : kill instruction in IF/ID
//     stall_count_o   : wrapping count of cycles with if_stall_o=1
module hazard_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_controller_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
  } track_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Only the EX position ever needs the load flag (load-use is detected
  // against EX alone), so it is kept beside the EX slot instead of being
  // carried down into MEM/WB where nothing would read it.
  track_t     ex_q;
  logic       ex_load_q;
  track_t     mem_q;
  track_t     wb_q;

  state_e     state_q;
  state_e     state_d;

  logic [CNT_W-1:0] stall_cnt_q;

  logic       any_valid;
  logic       ex_hit_a;
  logic       ex_hit_b;
  logic       load_use;
  logic       need_drain;
  logic       issue;
  logic       if_stall;
  logic       id_stall;
  logic       id_flush;
  logic       if_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  function automatic logic hit(input track_t s, input logic [4:0] rs,
                               input logic use_rs);
    return s.valid && s.we && (s.rd == rs) && (rs != 5'd0) && use_rs;
  endfunction

  function automatic logic [1:0] fwd_sel(input track_t ex, input track_t mem,
                                         input track_t wb, input logic [4:0] rs,
                                         input logic use_rs);
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(ex, rs, use_rs)) begin
      sel = 2'd1;
    end else if (hit(mem, rs, use_rs)) begin
      sel = 2'd2;
    end else if (hit(wb, rs, use_rs)) begin
      sel = 2'd3;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding; selects stay meaningful while stalled.
  always_comb begin
    any_valid  = ex_q.valid | mem_q.valid | wb_q.valid;
    ex_hit_a   = hit(ex_q, hz.id_rs1_i, hz.id_use_rs1_i);
    ex_hit_b   = hit(ex_q, hz.id_rs2_i, hz.id_use_rs2_i);
    load_use   = hz.id_valid_i & ex_load_q & (ex_hit_a | ex_hit_b);
    need_drain = hz.id_valid_i & hz.id_serial_i & any_valid;
    fwd_a      = fwd_sel(ex_q, mem_q, wb_q, hz.id_rs1_i, hz.id_use_rs1_i);
    fwd_b      = fwd_sel(ex_q, mem_q, wb_q, hz.id_rs2_i, hz.id_use_rs2_i);
  end

  // Next-state and control outputs.
  always_comb begin
    state_d  = state_q;
    if_stall = 1'b0;
    id_stall = 1'b0;
    id_flush = 1'b0;
    issue    = 1'b0;

    if (hz.mem_busy_i) begin
      // Whole-pipeline freeze: nothing issues, nothing is flushed.
      if_stall = 1'b1;
      id_stall = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (need_drain) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
            state_d  = DRAIN;
          end else if (load_use) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
          end else begin
            issue = hz.id_valid_i;
          end
        end
        DRAIN: begin
          if (any_valid) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
          end else begin
            // Pipeline empty: the waiting serial op goes this cycle.
            state_d = RUN;
            issue   = hz.id_valid_i;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    // Redirect only on a real issue; a stalled branch's compare is stale.
    if_flush = issue & (hz.id_jump_i | (hz.id_branch_i & hz.take_branch_i));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q      <= '0;
      ex_load_q <= 1'b0;
      mem_q     <= '0;
      wb_q      <= '0;
    end else if (!hz.mem_busy_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (issue) begin
        ex_q.valid <= 1'b1;
        ex_q.rd    <= hz.id_rd_i;
        ex_q.we    <= hz.id_we_i;
        ex_load_q  <= hz.id_load_i;
      end else begin
        ex_q      <= '0;
        ex_load_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (if_stall) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.forward_a_sel_o = fwd_a;
  assign hz.forward_b_sel_o = fwd_b;
  assign hz.if_stall_o      = if_stall;
  assign hz.id_stall_o      = id_stall;
  assign hz.id_flush_o      = id_flush;
  assign hz.if_flush_o      = if_flush;
  assign hz.stall_count_o   = stall_cnt_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the decode stage.
- Tracks destination registers in flight in EX/MEM/WB and drives the decode-stage forwarding mux selects.
- Generates IF/ID stalls, ID/EX bubbles and IF flushes for load-use, branch/jump redirects, CSR/system-op serialisation and data-memory wait.
- Also exposes a stall-cycle performance counter.

Parameters:
- CNT_W, 32, width of stall_count_o.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i  in  5  rs1 address of ID instruction
- id_rs2_i  in  5  rs2 address of ID instruction
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- id_rd_i  in  5  destination of ID instruction
- id_we_i  in  1  ID instruction writes rd
- id_load_i  in  1  ID instruction is a load
- id_serial_i  in  1  ID instruction is CSR/syscall/break (must issue into an empty EX/MEM/WB)
- id_branch_i  in  1  ID is a conditional branch
- id_jump_i  in  1  ID is jal/jalr
- take_branch_i  in  1  branch comparator result
- mem_busy_i  in  1  data memory not ready; whole pipeline freezes
- forward_a_sel_o  out  2  0=regfile, 1=EX, 2=MEM, 3=WB
- forward_b_sel_o  out  2  same encoding, rs2
- if_stall_o  out  1  hold PC and IF/ID
- id_stall_o  out  1  hold ID/EX (memory freeze only)
- id_flush_o  out  1  load bubble into ID/EX
- if_flush_o  out  1  kill instruction in IF/ID
- stall_count_o  out  CNT_W  cycles with if_stall_o=1, wraps

Behaviour:
- Tracker: three registered slots EX, MEM, WB, each holding {valid, rd, we, load}. Reset clears all slots to zero (bubble).
- Slot advance per cycle, unless mem_busy_i=1 (then all slots hold):
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields when ID issues, else bubble.
  - ID issues when id_valid_i=1, state=RUN, no load-use hazard and no drain required.
- Hit definition: slot.valid && slot.we && slot.rd==rs && rs!=0 && use_rs.
- Forward select priority: EX > MEM > WB > regfile. Computed combinationally from the slots and ID inputs. It is valid even while stalling.
- Load-use: an EX-slot hit where EX.load=1.
  - Response: if_stall_o=1, id_flush_o=1, EX gets a bubble. Lasts exactly 1 cycle.
  - The next cycle the load sits in MEM and is forwarded with sel=2.
- FSM states: RUN, DRAIN.
  - RUN → DRAIN when id_valid_i && id_serial_i && any slot valid. Stall and bubble in that cycle.
  - In DRAIN: if_stall_o=1, id_flush_o=1.
  - DRAIN → RUN when all slots are invalid. The serial op issues in that same cycle.
  - A serial op with empty slots in RUN issues with no stall.
- Redirect: if_flush_o=1 when ID issues AND (id_jump_i OR (id_branch_i AND take_branch_i)).
  - Redirect is suppressed while stalled, because take_branch_i is meaningless during a load-use stall.
- mem_busy_i=1 overrides everything:
  - if_stall_o=1, id_stall_o=1, id_flush_o=0, if_flush_o=0.
  - FSM and slots hold.
- Outputs at reset: forward selects 0, all stall/flush 0, stall_count_o=0, state RUN.
- stall_count_o increments by 1 on every clock where if_stall_o=1. Wraps from all-ones to 0.
- Reset asserted mid-stall or mid-DRAIN: immediate return to the reset values, with no dependence on the clock.
- id_valid_i=0: no hazard, no redirect. EX receives a bubble.

Test Plan:
- ALU write x5 then next instruction reads x5 as rs1 → forward_a_sel_o=1. The cycle after, with an intervening independent instruction → sel=2, then sel=3.
- Same rd=x7 in EX and MEM, ID reads x7 on rs2 → forward_b_sel_o=1 (EX priority). rd=x0 in EX with ID reading x0 → sel=0.
- Load x3 followed by add using x3 → if_stall_o=1 and id_flush_o=1 for exactly 1 cycle, then forward_a_sel_o=2, no further stall; stall_count_o=1.
- CSR op decoded with 3 valid slots → DRAIN for 3 cycles with stall=1, issue on the 4th. mem_busy_i pulsed 2 cycles mid-DRAIN extends the drain by 2 cycles; id_stall_o=1 during the pulse.
- Taken branch with take_branch_i=1 → if_flush_o=1 for 1 cycle. Same branch depending on a load in EX → if_flush_o=0 during the stall, then 1 on the issue cycle.
- Assert rst_i=0 asynchronously during DRAIN → all outputs 0 and slots empty before the next edge; operation resumes in RUN after release.
